// File: rtl/lut_layer_pkg.sv
// Shared constants, wiring table and FSM state type for the layer-1 LUT scheduler.
package lut_layer_pkg;

    localparam int IN_W        = 128;
    localparam int BITS        = 4;
    localparam int FANIN       = 3;
    localparam int NUM_NEURONS = 5;
    localparam int ADDR_W      = FANIN * BITS;
    localparam int OUT_W       = NUM_NEURONS * BITS;
    localparam int IDX_W       = 3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    typedef logic [4:0] group_idx_t;

    // Row n lists the input groups feeding neuron n, most significant address nibble first.
    localparam group_idx_t L1_WIRING [NUM_NEURONS][FANIN] = '{
        '{5'd0, 5'd6,  5'd26},
        '{5'd7, 5'd10, 5'd24},
        '{5'd5, 5'd14, 5'd23},
        '{5'd3, 5'd17, 5'd22},
        '{5'd4, 5'd6,  5'd25}
    };

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/lut_addr_gather.sv
// Selects the three input groups of the current neuron and concatenates them
// into that neuron's LUT address.
module lut_addr_gather
    import lut_layer_pkg::*;
(
    input  logic [IN_W-1:0]   i_vec,
    input  logic [IDX_W-1:0]  i_idx,
    output logic [ADDR_W-1:0] o_addr
);

    always_comb begin
        // NOTE: default assignment first so every path drives o_addr and no latch is inferred.
        o_addr = '0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            if (i_idx == IDX_W'(n)) begin
                for (int f = 0; f < FANIN; f++) begin
                    o_addr[(FANIN-1-f)*BITS +: BITS] = i_vec[int'(L1_WIRING[n][f])*BITS +: BITS];
                end
            end
        end
    end

endmodule

// File: rtl/neuron_lut_scheduler.sv
// Sequences the five layer-1 neurons through one shared LUT memory and packs
// the returned nibbles into the 20-bit layer output.
module neuron_lut_scheduler
    import lut_layer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_data,
    output logic                    lut_rd_en,
    output logic [IDX_W+ADDR_W-1:0] lut_addr,
    input  logic [BITS-1:0]         lut_rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data
);

    sched_state_t      r_state;
    logic [IN_W-1:0]   r_vec;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  r_cap_idx;
    logic              r_rd_en;
    logic              r_cap_en;
    logic              r_out_valid;
    logic [OUT_W-1:0]  r_result;
    logic [ADDR_W-1:0] w_addr;

    lut_addr_gather u_gather (
        .i_vec  (r_vec),
        .i_idx  (r_idx),
        .o_addr (w_addr)
    );

    // Held low while rst is asserted so no vector can slip in during reset.
    assign in_ready  = (r_state == IDLE) && !rst;
    assign lut_rd_en = r_rd_en;
    assign lut_addr  = r_rd_en ? {r_idx, w_addr} : '0;
    assign out_valid = r_out_valid;
    assign out_data  = r_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state     <= IDLE;
            r_vec       <= '0;
            r_idx       <= '0;
            r_cap_idx   <= '0;
            r_rd_en     <= 1'b0;
            r_cap_en    <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else begin
            // Read data lags the strobe by one cycle, so the capture slot trails idx.
            r_cap_en  <= r_rd_en;
            r_cap_idx <= r_idx;
            if (r_cap_en) begin
                r_result[int'(r_cap_idx)*BITS +: BITS] <= lut_rd_data;
            end

            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        r_vec   <= in_data;
                        r_idx   <= '0;
                        r_rd_en <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_rd_en <= 1'b0;
                        r_state <= DRAIN;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_lut_scheduler.sv
// Scoreboard bench for neuron_lut_scheduler with a 1-cycle-latency LUT memory
// model returning addr[3:0] ^ neuron index.
module tb_neuron_lut_scheduler;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] in_data = '0;
    logic [3:0]   lut_rd_data = 4'hF;
    logic         in_ready;
    logic         lut_rd_en;
    logic [14:0]  lut_addr;
    logic         out_valid;
    logic [19:0]  out_data;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int read_count = 0;

    logic [14:0] exp_reads[$];
    logic [19:0] exp_outs[$];
    int          hs_cycles[$];

    int wiring [5][3] = '{'{0, 6, 26}, '{7, 10, 24}, '{5, 14, 23}, '{3, 17, 22}, '{4, 6, 25}};

    neuron_lut_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .lut_rd_en   (lut_rd_en),
        .lut_addr    (lut_addr),
        .lut_rd_data (lut_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: data valid for the whole cycle after the strobe; 0xF otherwise.
    always @(posedge clk) begin
        lut_rd_data <= lut_rd_en ? (lut_addr[3:0] ^ {1'b0, lut_addr[14:12]}) : 4'hF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [14:0] gather(input logic [127:0] v, input int n);
        return {3'(n), v[wiring[n][0]*4 +: 4], v[wiring[n][1]*4 +: 4], v[wiring[n][2]*4 +: 4]};
    endfunction

    // Monitor: pops expectations whenever the DUT presents a read or a result.
    always @(negedge clk) begin
        if (lut_rd_en) begin
            read_count++;
            check("read_queued", 32'(exp_reads.size() > 0), 32'd1);
            if (exp_reads.size() > 0) check("lut_addr", lut_addr, exp_reads.pop_front());
        end
        if (out_valid && out_ready) begin
            hs_cycles.push_back(cyc);
            check("out_queued", 32'(exp_outs.size() > 0), 32'd1);
            if (exp_outs.size() > 0) check("out_data", out_data, exp_outs.pop_front());
        end
    end

    task automatic push_vec(input logic [127:0] v, input logic [19:0] exp);
        for (int n = 0; n < 5; n++) exp_reads.push_back(gather(v, n));
        exp_outs.push_back(exp);
    endtask

    // Offers v until accepted; returns 1 time unit after the handshake edge.
    task automatic send(input logic [127:0] v, input logic hold);
        int t = 0;
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = hold;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_outs.size() != 0 || exp_reads.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 32'(exp_outs.size() + exp_reads.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] v1, v2, v3, v5;
        logic [127:0] vecs[4];
        logic [19:0]  exps[4];
        int t;
        int rc0;

        v1 = '0; v1[3:0] = 4'hA; v1[27:24] = 4'h5; v1[107:104] = 4'h3;
        v2 = '1;
        v3 = '0; v3[107:104] = 4'h7; v3[99:96] = 4'h1; v3[95:92] = 4'h9;
        v3[91:88] = 4'h6; v3[103:100] = 4'h2;
        v5 = '0; v5[3:0] = 4'h1; v5[31:28] = 4'h2; v5[23:20] = 4'h3; v5[15:12] = 4'h4;
        v5[19:16] = 4'h5; v5[71:68] = 4'h8; v5[107:104] = 4'hC;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("in_ready_in_rst", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_rd_en", 32'(lut_rd_en), 32'd0);
        check("rst_lut_addr", lut_addr, 32'd0);

        // Zero vector with exact per-cycle latency.
        @(posedge clk);
        #1;
        push_vec('0, 20'h43210);
        send('0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("lat_rd_en", 32'(lut_rd_en), 32'(k <= 5));
            check("lat_out_valid", 32'(out_valid), 32'(k == 7));
            check("lat_in_ready", 32'(in_ready), 32'(k == 8));
        end
        @(posedge clk);
        #1;

        // Gather with hand-derived addresses.
        exp_reads.push_back({3'd0, 12'hA53});
        exp_reads.push_back({3'd1, 12'h000});
        exp_reads.push_back({3'd2, 12'h000});
        exp_reads.push_back({3'd3, 12'h000});
        exp_reads.push_back({3'd4, 12'h050});
        exp_outs.push_back(20'h43213);
        send(v1, 1'b0);
        wait_drain();

        // Backpressure with a second vector pending.
        out_ready = 1'b0;
        push_vec(v2, 20'hBCDEF);
        send(v2, 1'b0);
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("bp_out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        in_data  = v3;
        push_vec(v3, 20'h65B07);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_hold_data", out_data, 32'hBCDEF);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_rd_en", 32'(lut_rd_en), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_idle_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_second_accepted", 32'(lut_rd_en), 32'd1);
        wait_drain();

        // Reset during ISSUE at idx 2.
        for (int n = 0; n < 5; n++) exp_reads.push_back(gather(v2, n));
        send(v2, 1'b0);
        t = 0;
        @(negedge clk);
        while (!(lut_rd_en && lut_addr[14:12] == 3'd2) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("rst_found_idx2", 32'(lut_addr[14:12]), 32'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_reads.delete();
        @(negedge clk);
        check("post_rst_rd_en", 32'(lut_rd_en), 32'd0);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_out_data", out_data, 32'd0);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("late_return_ignored", out_data, 32'd0);
        @(posedge clk);
        #1;
        push_vec(v5, 20'h4321C);
        send(v5, 1'b0);
        wait_drain();

        // Back-to-back vectors.
        vecs = '{'0, v1, v2, v3};
        exps = '{20'h43210, 20'h43213, 20'hBCDEF, 20'h65B07};
        hs_cycles.delete();
        rc0 = read_count;
        for (int i = 0; i < 4; i++) begin
            push_vec(vecs[i], exps[i]);
            send(vecs[i], 1'b1);
        end
        in_valid = 1'b0;
        wait_drain();
        check("b2b_reads", 32'(read_count - rc0), 32'd20);
        check("b2b_results", 32'(hs_cycles.size()), 32'd4);
        for (int i = 1; i < hs_cycles.size(); i++) begin
            check("b2b_interval", 32'(hs_cycles[i] - hs_cycles[i-1]), 32'd8);
        end

        // Idle robustness.
        rc0 = read_count;
        repeat (20) begin
            @(posedge clk);
            #1 out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("idle_out_valid", 32'(out_valid), 32'd0);
            check("idle_rd_en", 32'(lut_rd_en), 32'd0);
        end
        check("idle_reads", 32'(read_count - rc0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
